// File: rtl/card_dealer.sv
// Single-deck card dealer: draws without replacement by walking a 6-bit LFSR over a used-slot bitmap.
// Define DEALER_SEED_MIX_EN to also step the LFSR in IDLE, so the deal order depends on request timing.
module card_dealer #(
  parameter logic [5:0] LFSR_SEED  = 6'h01,
  parameter int         NUM_CARDS  = 52,
  parameter logic [3:0] FACE_VALUE = 4'd10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_dealReq,
  input  logic       i_shuffle,
  output logic       o_addNewCard,
  output logic [3:0] o_newCard,
  output logic       o_busy,
  output logic [5:0] o_cardsRemaining,
  output logic       o_deckEmpty
);

  // Handshake: o_addNewCard is a one-cycle valid with o_newCard; there is no ready,
  // and i_dealReq is only accepted in IDLE (o_busy low), never queued.
  typedef enum logic {ST_IDLE = 1'b0, ST_SEARCH = 1'b1} state_e;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [5:0] SEED      = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;
  localparam logic [5:0] DECK_SIZE = 6'(NUM_CARDS);

  state_e      state_q, state_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic [63:0] used_q, used_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [3:0]  new_card_q, new_card_d;
  logic        add_q, add_d;

  logic [5:0]  lfsr_next;
  logic [5:0]  idx;
  logic [5:0]  rank;
  logic        hit;

  assign lfsr_next = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  assign idx       = lfsr_q - 6'd1;
  assign rank      = idx % 6'd13;
  assign hit       = (idx < DECK_SIZE) && !used_q[idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      used_q      <= '0;
      remaining_q <= DECK_SIZE;
      new_card_q  <= 4'd0;
      add_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      used_q      <= used_d;
      remaining_q <= remaining_d;
      new_card_q  <= new_card_d;
      add_q       <= add_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    used_d      = used_q;
    remaining_d = remaining_q;
    new_card_d  = new_card_q;
    add_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef DEALER_SEED_MIX_EN
        lfsr_d = lfsr_next;
`else
        lfsr_d = lfsr_q;
`endif
        if (i_shuffle) begin
          used_d      = '0;
          lfsr_d      = SEED;
          remaining_d = DECK_SIZE;
        end else if (i_dealReq && (remaining_q != 6'd0)) begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (i_shuffle) begin
          used_d      = '0;
          lfsr_d      = SEED;
          remaining_d = DECK_SIZE;
          state_d     = ST_IDLE;
        end else begin
          lfsr_d = lfsr_next;
          if (hit) begin
            used_d[idx] = 1'b1;
            new_card_d  = (rank < 6'd9) ? (rank[3:0] + 4'd1) : FACE_VALUE;
            add_d       = 1'b1;
            remaining_d = remaining_q - 6'd1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_addNewCard     = add_q;
  assign o_newCard        = new_card_q;
  assign o_busy           = (state_q == ST_SEARCH);
  assign o_cardsRemaining = remaining_q;
  assign o_deckEmpty      = (remaining_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a deck model built on the 63-step LFSR cycle.
module tb_card_dealer;
  localparam int NCARDS = 52;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_dealReq;
  logic       i_shuffle;
  logic       o_addNewCard;
  logic [3:0] o_newCard;
  logic       o_busy;
  logic [5:0] o_cardsRemaining;
  logic       o_deckEmpty;

  int checks = 0;
  int errors = 0;

  // Model: the deck order is fixed by the LFSR cycle; a deal takes the first
  // unused in-range slot at or after the current cycle position.
  int seq[63];
  int pos_m;
  bit used_m[NCARDS];
  int rem_m;
  int hist[11];

  card_dealer dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_dealReq        (i_dealReq),
    .i_shuffle        (i_shuffle),
    .o_addNewCard     (o_addNewCard),
    .o_newCard        (o_newCard),
    .o_busy           (o_busy),
    .o_cardsRemaining (o_cardsRemaining),
    .o_deckEmpty      (o_deckEmpty)
  );

  always #5 i_clk = ~i_clk;

  function automatic int card_value(input int idx);
    int r;
    r = idx % 13;
    return (r < 9) ? r + 1 : 10;
  endfunction

  task automatic model_reset();
    pos_m = 0;
    rem_m = NCARDS;
    foreach (used_m[i]) used_m[i] = 1'b0;
  endtask

  task automatic model_peek(output int val, output int lat, output int hit_pos);
    val = 0; lat = 0; hit_pos = -1;
    for (int k = 0; k < 63; k++) begin
      int p;
      int idx;
      p = (pos_m + k) % 63;
      idx = seq[p] - 1;
      if (idx < NCARDS && !used_m[idx]) begin
        val = card_value(idx); lat = k + 1; hit_pos = p;
        break;
      end
    end
  endtask

  // Issues one request at a negedge in IDLE and returns at the negedge of the pulse cycle.
  task automatic do_deal(input string tag, output int got);
    int exp_val, exp_lat, hp, n, busy_cnt;
    bit seen;
    model_peek(exp_val, exp_lat, hp);
    i_dealReq = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dealReq = 1'b0;
    got = 0;
    if (rem_m == 0) begin
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (o_addNewCard || o_busy) seen = 1'b1;
        @(negedge i_clk);
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL %s empty_req: pulse_or_busy seen=1 required 0", tag);
      end
      return;
    end
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (n < 70) begin
      if (o_addNewCard) begin seen = 1'b1; break; end
      if (o_busy) busy_cnt++;
      @(negedge i_clk);
      n++;
    end
    used_m[seq[hp] - 1] = 1'b1;
    pos_m = (hp + 1) % 63;
    rem_m--;
    got = int'(o_newCard);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no pulse within %0d edges", tag, n);
      return;
    end
    checks++;
    if (n != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", tag, n, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy_cnt, exp_lat);
    end
    checks++;
    if (int'(o_newCard) != exp_val) begin
      errors++; $display("FAIL %s value: got %0d required %0d", tag, o_newCard, exp_val);
    end
    checks++;
    if (int'(o_cardsRemaining) != rem_m || o_deckEmpty !== (rem_m == 0)) begin
      errors++;
      $display("FAIL %s remaining: got %0d/empty=%0b required %0d", tag, o_cardsRemaining, o_deckEmpty, rem_m);
    end
  endtask

  task automatic do_shuffle();
    i_shuffle = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
    model_reset();
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (o_addNewCard || o_busy) seen = 1'b1;
      @(negedge i_clk);
    end
    checks++;
    if (seen || int'(o_cardsRemaining) != rem_m) begin
      errors++;
      $display("FAIL %s quiet: activity=%0b remaining=%0d required activity=0 remaining=%0d", tag, seen, o_cardsRemaining, rem_m);
    end
  endtask

  // Deals until the next request is predicted to stay in SEARCH for at least 3 edges.
  task automatic deal_until_long_search(input string tag);
    int v, l, h, got;
    for (int k = 0; k < NCARDS; k++) begin
      model_peek(v, l, h);
      if (l >= 3 || rem_m <= 1) break;
      do_deal(tag, got);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_dealReq = 1'b0; i_shuffle = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_addNewCard !== 1'b0) begin errors++; $display("FAIL reset_add: got %0b required 0", o_addNewCard); end
    checks++;
    if (o_newCard !== 4'd0) begin errors++; $display("FAIL reset_card: got %0d required 0", o_newCard); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", o_busy); end
    checks++;
    if (o_cardsRemaining !== 6'd52) begin errors++; $display("FAIL reset_remaining: got %0d required 52", o_cardsRemaining); end
    checks++;
    if (o_deckEmpty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b required 0", o_deckEmpty); end
  endtask

  task automatic test_first_deals();
    int want[3];
    int got;
    want[0] = 1; want[1] = 2; want[2] = 4;
    for (int k = 0; k < 3; k++) begin
      do_deal("first", got);
      checks++;
      if (got != want[k]) begin
        errors++; $display("FAIL first_card%0d: got %0d required %0d", k, got, want[k]);
      end
    end
    checks++;
    if (o_cardsRemaining !== 6'd49) begin errors++; $display("FAIL first_remaining: got %0d required 49", o_cardsRemaining); end
  endtask

  task automatic test_back_to_back();
    int got;
    bit hist_ok;
    do_shuffle();
    foreach (hist[i]) hist[i] = 0;
    for (int k = 0; k < NCARDS; k++) begin
      do_deal("b2b", got);
      if (got >= 1 && got <= 10) hist[got]++;
    end
    hist_ok = 1'b1;
    for (int v = 1; v <= 10; v++)
      if (hist[v] != ((v == 10) ? 16 : 4)) hist_ok = 1'b0;
    checks++;
    if (!hist_ok) begin
      errors++;
      $display("FAIL b2b_histogram: got %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d required 4x9 then 16",
               hist[1], hist[2], hist[3], hist[4], hist[5], hist[6], hist[7], hist[8], hist[9], hist[10]);
    end
    checks++;
    if (o_deckEmpty !== 1'b1 || o_cardsRemaining !== 6'd0) begin
      errors++; $display("FAIL b2b_empty: got empty=%0b remaining=%0d required 1/0", o_deckEmpty, o_cardsRemaining);
    end
    do_deal("b2b_53rd", got);
  endtask

  task automatic test_shuffle_empty();
    int got;
    do_shuffle();
    checks++;
    if (o_cardsRemaining !== 6'd52 || o_deckEmpty !== 1'b0) begin
      errors++; $display("FAIL shuffle_refill: got remaining=%0d empty=%0b required 52/0", o_cardsRemaining, o_deckEmpty);
    end
    do_deal("after_shuffle", got);
    checks++;
    if (got != 1) begin errors++; $display("FAIL shuffle_first_card: got %0d required 1", got); end
  endtask

  task automatic test_reset_mid_search();
    deal_until_long_search("pre_reset");
    i_dealReq = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dealReq = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_search_busy: got %0b required 1", o_busy); end
    @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_addNewCard !== 1'b0 || o_newCard !== 4'd0 ||
        o_cardsRemaining !== 6'd52 || o_deckEmpty !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got busy=%0b add=%0b card=%0d remaining=%0d empty=%0b required 0/0/0/52/0",
               o_busy, o_addNewCard, o_newCard, o_cardsRemaining, o_deckEmpty);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    check_quiet("rst_release", 12);
  endtask

  task automatic test_shuffle_in_search();
    deal_until_long_search("pre_abort");
    i_dealReq = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dealReq = 1'b0;
    do_shuffle();
    check_quiet("shuffle_abort", 10);
  endtask

  task automatic test_shuffle_with_req();
    int got;
    for (int k = 0; k < 3; k++) do_deal("pre_tie", got);
    i_shuffle = 1'b1;
    i_dealReq = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
    i_dealReq = 1'b0;
    model_reset();
    check_quiet("shuffle_wins", 10);
    checks++;
    if (o_cardsRemaining !== 6'd52) begin errors++; $display("FAIL tie_remaining: got %0d required 52", o_cardsRemaining); end
  endtask

  task automatic test_random();
    int got;
    for (int op = 0; op < 120; op++) begin
      if ($urandom_range(0, 99) < 6) do_shuffle();
      else do_deal("random", got);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end
  endtask

  initial begin
    int s;
    s = 1;
    for (int k = 0; k < 63; k++) begin
      seq[k] = s;
      s = ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
    end
    test_reset();
    test_first_deals();
    test_back_to_back();
    test_shuffle_empty();
    test_reset_mid_search();
    test_shuffle_in_search();
    test_shuffle_with_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
